// File: rtl/switch_toggle_bank.sv
// Multi-channel push-button front end: 2-flop sync, counter debounce, edge qualify, LED toggle.
// Debounced level follows a settled input after DEBOUNCE_CYCLES+2 edges; event/toggle one edge later.
module switch_toggle_bank #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int EDGE_MODE       = 0,
  parameter int LED_ACTIVE_LOW  = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_Switch_Stable,
  output logic [NUM_CH-1:0] o_Event,
  output logic [NUM_CH-1:0] o_LED
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_CH-1:0] LED_POL = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] event_q, event_d;
  logic [NUM_CH-1:0] tog_q, tog_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] rise, fall, qual;

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any return resets the count.
  always_comb begin
    stable_d = stable_q;
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n] = '0;
      if (sync2_q[n] != stable_q[n]) begin
        if (cnt_q[n] == CNT_MAX) begin
          stable_d[n] = sync2_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rise = stable_q & ~prev_q;
    fall = ~stable_q & prev_q;
    if (EDGE_MODE == 1) begin
      qual = rise;
    end else if (EDGE_MODE == 2) begin
      qual = rise | fall;
    end else begin
      qual = fall;
    end
    event_d = qual;
    // Clear has priority, so an event landing on the same edge is dropped for the toggle.
    tog_d   = i_Clear ? '0 : (tog_q ^ qual);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      event_q  <= '0;
      tog_q    <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      sync1_q  <= i_Switch;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      event_q  <= event_d;
      tog_q    <= tog_d;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign o_Switch_Stable = stable_q;
  assign o_Event         = event_q;
  assign o_LED           = tog_q ^ LED_POL;

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Bench for switch_toggle_bank: three instances (release/press/both edge modes) share the stimulus.
module tb_switch_toggle_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       clr;
  logic [3:0] stb0, ev0, led0;
  logic [3:0] stb1, ev1, led1;
  logic [3:0] stb2, ev2, led2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cnt1    = 0;
  int cnt2    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_toggle_bank #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .LED_ACTIVE_LOW(1)) dut0 (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw), .i_Clear(clr),
    .o_Switch_Stable(stb0), .o_Event(ev0), .o_LED(led0));
  switch_toggle_bank #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .LED_ACTIVE_LOW(1)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw), .i_Clear(clr),
    .o_Switch_Stable(stb1), .o_Event(ev1), .o_LED(led1));
  switch_toggle_bank #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .LED_ACTIVE_LOW(1)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw), .i_Clear(clr),
    .o_Switch_Stable(stb2), .o_Event(ev2), .o_LED(led2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // A release driven when cyc==c shows up as an event at the negedge where cyc==c+7.
  task automatic push_ev(input logic [3:0] ev);
    exp_t e;
    e.cyc = cyc + 7;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cnt1 += int'(ev1[2]);
      cnt2 += int'(ev2[2]);
      if (ev0 != 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'(ev0), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("event_value", 32'(ev0), 32'(e.ev));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    sw  = 4'b0;
    clr = 1'b0;
    repeat (3) tick();
    check("rst_led_during", 32'(led0), 32'hf);
    check("rst_stable_during", 32'(stb0), 32'h0);
    rst = 1'b0;
    tick();
    check("rst_led", 32'(led0), 32'hf);
    check("rst_event", 32'(ev0), 32'h0);
    check("rst_stable", 32'(stb0), 32'h0);

    // Press on ch0: stable rises at the 6th edge, no event in release mode.
    sw[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("lat_rise", 32'(stb0[0]), 32'(i == 6));
    end
    repeat (2) tick();
    sw[0] = 1'b0;
    push_ev(4'b0001);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("lat_fall", 32'(stb0[0]), 32'(i < 6));
    end
    tick();
    check("rel_event", 32'(ev0), 32'h1);
    check("rel_led", 32'(led0), 32'he);
    tick();
    check("rel_event_one_cycle", 32'(ev0), 32'h0);

    // Bounce on ch1 every 3 cycles never satisfies the 4-cycle filter.
    for (int k = 0; k < 10; k++) begin
      sw[1] = ~sw[1];
      repeat (3) begin
        tick();
        check("bounce_hold", 32'(stb0[1]), 32'h0);
      end
    end
    sw[1] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("bounce_settle", 32'(stb0[1]), 32'(i == 6));
    end

    // Two press/release cycles on ch2 across the three edge modes.
    repeat (2) begin
      sw[2] = 1'b1;
      repeat (8) tick();
      sw[2] = 1'b0;
      push_ev(4'b0100);
      repeat (8) tick();
    end
    check("mode1_events", 32'(cnt1), 32'd2);
    check("mode2_events", 32'(cnt2), 32'd4);
    check("mode1_led", 32'(led1[2]), 32'h1);
    check("mode2_led", 32'(led2[2]), 32'h1);
    check("mode0_led", 32'(led0), 32'he);

    // Clear collision on ch3.
    sw[3] = 1'b1;
    repeat (8) tick();
    sw[3] = 1'b0;
    push_ev(4'b1000);
    repeat (8) tick();
    check("ch3_toggled", 32'(led0), 32'h6);
    sw[3] = 1'b1;
    repeat (8) tick();
    sw[3] = 1'b0;
    push_ev(4'b1000);
    repeat (6) tick();
    clr = 1'b1;
    tick();
    check("clear_event", 32'(ev0), 32'h8);
    check("clear_led", 32'(led0), 32'hf);
    clr = 1'b0;
    tick();
    check("clear_event_end", 32'(ev0), 32'h0);
    check("clear_led_hold", 32'(led0), 32'hf);

    // Async reset with ch0's counter mid-count.
    sw[0] = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_stable", 32'(stb0), 32'h0);
    check("arst_event", 32'(ev0), 32'h0);
    check("arst_led", 32'(led0), 32'hf);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("arst_restart", 32'(stb0), (i == 6) ? 32'h3 : 32'h0);
    end
    repeat (10) tick();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
